// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for piso_tx.
// The master drives the parallel word. The slave (the serializer) drives the serial side.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             d_out;
    logic             d_valid;
    logic             d_last;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  d_out,
        input  d_valid,
        input  d_last,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output d_out,
        output d_valid,
        output d_last,
        output busy
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a valid/ready word input.
// It can reload on the last bit of a word, so back-to-back words leave no gap.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             at_last;
    logic             ready;
    logic             accept;

    // Register moved one position toward the output end, with zero fill.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
                assign shifted[gi] = 1'b0;
            end else begin : g_move
                assign shifted[gi] = shift_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_fill
                assign shifted[gi] = 1'b0;
            end else begin : g_move
                assign shifted[gi] = shift_reg[gi+1];
            end
        end
    end

    assign at_last = (count_reg == LAST_CNT);
    assign ready   = (state_reg == IDLE) || at_last;
    assign accept  = bus.in_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_next = shift_reg;
        if (accept) begin
            state_next = SHIFT;
            count_next = '0;
            shift_next = bus.in_data;
        end else if (state_reg == SHIFT) begin
            shift_next = shifted;
            if (at_last) begin
                state_next = IDLE;
                count_next = '0;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.in_ready = ready;
        bus.d_valid  = 1'b0;
        bus.d_last   = 1'b0;
        bus.busy     = 1'b0;
        bus.d_out    = 1'b0;
        if (state_reg == SHIFT) begin
            bus.d_valid = 1'b1;
            bus.d_last  = at_last;
            bus.busy    = 1'b1;
            bus.d_out   = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance receive the same stimulus.
// A word-level model checks both every cycle, and literal expectations pin known cycles.
module tb_piso_tx;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] ds = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W)) bus_a ();
    piso_tx_if #(.WIDTH(W)) bus_b ();

    assign bus_a.in_data  = in_data;
    assign bus_a.in_valid = in_valid;
    assign bus_b.in_data  = in_data;
    assign bus_b.in_valid = in_valid;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Downstream 4-bit left-shift register fed by the MSB-first instance
    always @(posedge clk) begin
        if (bus_a.d_valid) ds <= {ds[W-2:0], bus_a.d_out};
    end

    // Word-level model: index 0 is MSB-first, index 1 is LSB-first
    bit           m_on = 1'b0;
    bit           m_act [2];
    int           m_pos [2];
    logic [W-1:0] m_word [2];

    function automatic logic m_ready(int k);
        return !m_act[k] || (m_pos[k] == W - 1);
    endfunction

    function automatic logic m_bit(int k);
        if (!m_act[k]) return 1'b0;
        return (k == 0) ? m_word[k][W-1-m_pos[k]] : m_word[k][m_pos[k]];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_on = 1'b1;
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 1'b0;
                m_pos[k] = 0;
            end
        end else if (m_on) begin
            for (int k = 0; k < 2; k++) begin
                bit acc;
                acc = in_valid && m_ready(k);
                if (m_act[k]) begin
                    m_pos[k]++;
                    if (m_pos[k] == W) m_act[k] = 1'b0;
                end
                if (acc) begin
                    m_act[k]  = 1'b1;
                    m_pos[k]  = 0;
                    m_word[k] = in_data;
                end
            end
        end
    end

    task automatic chk(string name, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_on) begin
            chk("a_ready", bus_a.in_ready, m_ready(0));
            chk("a_valid", bus_a.d_valid, m_act[0]);
            chk("a_last",  bus_a.d_last,  m_act[0] && m_pos[0] == W - 1);
            chk("a_busy",  bus_a.busy,    m_act[0]);
            chk("a_dout",  bus_a.d_out,   m_bit(0));
            chk("b_ready", bus_b.in_ready, m_ready(1));
            chk("b_valid", bus_b.d_valid, m_act[1]);
            chk("b_last",  bus_b.d_last,  m_act[1] && m_pos[1] == W - 1);
            chk("b_busy",  bus_b.busy,    m_act[1]);
            chk("b_dout",  bus_b.d_out,   m_bit(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Literal check of both instances in the current cycle
    task automatic cyc(string tag, logic da, logic db, logic v, logic l, logic r, logic b);
        $display("%s t=%0t a:d=%b b:d=%b v=%b l=%b r=%b busy=%b", tag, $time,
                 bus_a.d_out, bus_b.d_out, bus_a.d_valid, bus_a.d_last, bus_a.in_ready, bus_a.busy);
        chk({tag, "_a_dout"}, bus_a.d_out, da);
        chk({tag, "_b_dout"}, bus_b.d_out, db);
        chk({tag, "_valid"},  bus_a.d_valid, v);
        chk({tag, "_last"},   bus_a.d_last, l);
        chk({tag, "_ready"},  bus_a.in_ready, r);
        chk({tag, "_busy"},   bus_a.busy, b);
        chk({tag, "_b_valid"}, bus_b.d_valid, v);
        chk({tag, "_b_ready"}, bus_b.in_ready, r);
    endtask

    // Two words offered with in_valid held: w0 first, then w1 until it is taken at edge 4
    task automatic run2(string tag, logic [W-1:0] w0, logic [W-1:0] w1,
                        logic [7:0] ea, logic [7:0] eb);
        in_data  = w0;
        in_valid = 1'b1;
        step();
        in_data = w1;
        for (int c = 1; c <= 8; c++) begin
            cyc(tag, ea[8-c], eb[8-c], 1'b1, (c == 4 || c == 8), (c == 4 || c == 8), 1'b1);
            step();
            if (c == 4) in_valid = 1'b0;
        end
        cyc({tag, "_end"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] words [6];

        // A word is offered during reset, but reset takes priority
        rst = 1'b1; in_valid = 1'b1; in_data = 4'b1011;
        step();
        step();
        cyc("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        cyc("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Single word 1011
        sa = 4'b1011;
        sb = 4'b1011;
        in_data = 4'b1011; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            cyc("single", sa[4-c], sb[c-1], 1'b1, c == 4, c == 4, 1'b1);
            step();
        end
        cyc("single_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("downstream", ds == 4'b1011, 1'b1);
        $display("downstream t=%0t ds=%b", $time, ds);

        // Back-to-back words, then a stalled 1111 offered during cycles 1..3
        run2("b2b",   4'b1011, 4'b0110, 8'b1011_0110, 8'b1101_0110);
        run2("stall", 4'b1011, 4'b1111, 8'b1011_1111, 8'b1101_1111);

        // Reset during cycle 2 abandons the word in progress
        in_data = 4'b1011; in_valid = 1'b1;
        step();
        in_data = 4'b0110;
        cyc("rmid1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        cyc("rmid2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        cyc("rmid3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        cyc("rmid4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Assorted words with varying gaps, checked only by the model
        words = '{4'b0000, 4'b1111, 4'b1001, 4'b0101, 4'b1110, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            in_data = words[i]; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            $display("word %0d data=%b t=%0t", i, words[i], $time);
            for (int g = 0; g < W - 1 + (i % 3); g++) step();
        end
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, meaning serial word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1, meaning 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port in_data  input  WIDTH  parallel word to serialize.
REQ-006 Port in_valid  input  1  in_data is presented for transfer.
REQ-007 Port in_ready  output  1  block can accept a word this cycle.
REQ-008 Port d_out  output  1  serial data bit; feeds the downstream shift register's d input.
REQ-009 Port d_valid  output  1  d_out carries a valid bit this cycle.
REQ-010 Port d_last  output  1  d_out is the final bit of the current word.
REQ-011 Port busy  output  1  a word is being serialized (state SHIFT).

Function
REQ-012 The block SHALL implement two states: IDLE and SHIFT.
REQ-013 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be captured into an internal WIDTH-bit shift register, bit counter SHALL be set to 0, state SHALL become SHIFT.
REQ-014 in_ready SHALL be 1 in IDLE and in SHIFT when counter = WIDTH-1; 0 otherwise (combinational from state/counter only, not from in_valid).
REQ-015 in_data and in_valid SHALL be ignored whenever in_ready=0; upstream holds the word until accepted.
REQ-016 In SHIFT: d_valid=1; d_out = shift register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0); each rising edge SHALL shift the register one position toward the output end and increment the counter.
REQ-017 d_last SHALL be 1 exactly when state is SHIFT and counter = WIDTH-1.
REQ-018 On the edge leaving counter = WIDTH-1: if a word is accepted, state SHALL stay SHIFT with counter 0 and the new word loaded (no gap bit); otherwise state SHALL become IDLE.
REQ-019 Latency: word accepted at edge N SHALL present its first bit in the cycle after edge N and its last bit in the cycle after edge N+WIDTH-1; exactly WIDTH valid bits per word.
REQ-020 In IDLE: d_valid=0, d_last=0, busy=0, d_out=0.
REQ-021 Counter width SHALL be ceil(log2(WIDTH)) bits minimum and SHALL never exceed WIDTH-1.
REQ-022 busy SHALL equal (state = SHIFT).

Reset
REQ-023 When rst=1 on a rising edge, state SHALL become IDLE, counter 0, shift register 0, regardless of in_valid or an in-progress word.
REQ-024 After reset: in_ready=1, d_out=0, d_valid=0, d_last=0, busy=0.
REQ-025 A word in progress at reset SHALL be abandoned without further valid bits; rst has priority over acceptance on the same edge.
REQ-026 Outputs before first reset are don't-care; the bench SHALL apply reset first.

Verification (WIDTH=4 unless stated)
REQ-027 Single word MSB_FIRST=1: in_data=4'b1011 accepted at edge 0 -> d_out 1,0,1,1 in cycles 1..4, d_valid=1 cycles 1..4, d_last=1 cycle 4 only, in_ready=0 cycles 1..3, IDLE cycle 5; downstream 4-bit left-shift register reads 4'b1011 after edge 4.
REQ-028 Back-to-back: 4'b1011 then 4'b0110 with in_valid held -> 8 contiguous valid bits 1,0,1,1,0,1,1,0, d_last in cycles 4 and 8, no idle cycle between.
REQ-029 Stall: in_valid=1 with in_data=4'b1111 during cycles 1..3 of a word -> not accepted until cycle 4 (in_ready=1), then serialized starting cycle 5.
REQ-030 Reset mid-word: rst=1 at edge 2 of word 4'b1011 -> from cycle 3 d_valid=0, d_out=0, busy=0, in_ready=1; no remaining bits emitted.
REQ-031 MSB_FIRST=0: in_data=4'b1011 -> d_out 1,1,0,1 in cycles 1..4.
REQ-032 Simultaneous rst=1 and in_valid=1 in IDLE -> word not accepted, block remains IDLE.
